// File: rtl/ftsd_scan_if.sv
// Scan controller bus: load/tick controls in, digit strobes and segments out.
interface ftsd_scan_if;
    logic        scan_tick;
    logic        load;
    logic [15:0] din;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  ftsd_ctl;
    logic [7:0]  segs;
    logic        frame_done;

    modport master (
        output scan_tick, load, din, dp_in, blank_lz,
        input  ftsd_ctl, segs, frame_done
    );

    modport slave (
        input  scan_tick, load, din, dp_in, blank_lz,
        output ftsd_ctl, segs, frame_done
    );
endinterface

// File: rtl/ftsd_scan.sv
// Four-digit multiplexed 7-segment scanner with frame-synchronous update,
// anti-ghost blanking and leading-zero suppression.
module ftsd_scan (
    input  logic       clk,
    input  logic       rst_n,
    ftsd_scan_if.slave bus
);
    logic [1:0]  idx;
    logic [15:0] sh_din, dsp_din;
    logic [3:0]  sh_dp, dsp_dp;
    logic        sh_blz, dsp_blz;
    logic        pending;
    logic        wrap, wrap_q;

    logic [3:0]  ctl_q;
    logic [7:0]  segs_q;
    logic        done_q;

    logic [3:0]  cur_val;
    logic        cur_dp;
    logic        cur_blank;
    logic [6:0]  seg_hi;
    logic [3:0]  ctl_nxt;
    logic [7:0]  segs_nxt;

    assign wrap = bus.scan_tick && (idx == 2'd3);

    always_comb begin
        cur_val   = dsp_din[{idx, 2'b00} +: 4];
        cur_dp    = dsp_dp[idx];
        cur_blank = 1'b0;
        seg_hi    = 7'b0000001;
        unique case (idx)
            2'd0: cur_blank = 1'b0;
            2'd1: cur_blank = dsp_blz && (dsp_din[15:4] == 12'h000);
            2'd2: cur_blank = dsp_blz && (dsp_din[15:8] == 8'h00);
            2'd3: cur_blank = dsp_blz && (dsp_din[15:12] == 4'h0);
        endcase
        case (cur_val)
            4'd0:    seg_hi = 7'b1111110;
            4'd1:    seg_hi = 7'b0110000;
            4'd2:    seg_hi = 7'b1101101;
            4'd3:    seg_hi = 7'b1111001;
            4'd4:    seg_hi = 7'b0110011;
            4'd5:    seg_hi = 7'b1011011;
            4'd6:    seg_hi = 7'b1011111;
            4'd7:    seg_hi = 7'b1110000;
            4'd8:    seg_hi = 7'b1111111;
            4'd9:    seg_hi = 7'b1111011;
            default: seg_hi = 7'b0000001;
        endcase
        // Blanked digits keep their strobe and dp so the frame timing is unchanged
        if (cur_blank) begin
            seg_hi = 7'b0000000;
        end
        segs_nxt = {~seg_hi, ~cur_dp};
        ctl_nxt  = ~(4'b0001 << idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= 2'd0;
            sh_din  <= 16'h0000;
            sh_dp   <= 4'h0;
            sh_blz  <= 1'b0;
            dsp_din <= 16'h0000;
            dsp_dp  <= 4'h0;
            dsp_blz <= 1'b0;
            pending <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            ctl_q   <= 4'b1111;
            segs_q  <= 8'hFF;
        end else begin
            wrap_q <= wrap;
            done_q <= wrap_q;
            if (bus.load) begin
                sh_din <= bus.din;
                sh_dp  <= bus.dp_in;
                sh_blz <= bus.blank_lz;
            end
            // A load on the wrap edge bypasses the shadow straight to display
            if (wrap && bus.load) begin
                dsp_din <= bus.din;
                dsp_dp  <= bus.dp_in;
                dsp_blz <= bus.blank_lz;
                pending <= 1'b0;
            end else if (wrap && pending) begin
                dsp_din <= sh_din;
                dsp_dp  <= sh_dp;
                dsp_blz <= sh_blz;
                pending <= 1'b0;
            end else if (bus.load) begin
                pending <= 1'b1;
            end
            if (bus.scan_tick) begin
                idx    <= idx + 2'd1;
                ctl_q  <= 4'b1111;
                segs_q <= 8'hFF;
            end else begin
                ctl_q  <= ctl_nxt;
                segs_q <= segs_nxt;
            end
        end
    end

    assign bus.ftsd_ctl   = ctl_q;
    assign bus.segs       = segs_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_ftsd_scan.sv
// Scoreboard bench for ftsd_scan: per-cycle expectations queued at drive time.
module tb_ftsd_scan;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    ftsd_scan_if bus();

    ftsd_scan dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] ctl;
        logic [7:0] segs;
        logic       fd;
    } exp_t;
    exp_t sb[$];

    logic [1:0]  m_idx;
    logic [15:0] m_sd, m_dd;
    logic [3:0]  m_sp, m_dp;
    logic        m_sb, m_db, m_pend, m_wq;
    logic [7:0]  seen [4];
    int          fd_count;
    bit          saw_stale;

    function automatic logic [7:0] ref_drive(input logic [1:0] i, input logic [15:0] d,
                                              input logic [3:0] dp, input logic blz);
        logic [3:0] v;
        logic [6:0] s;
        logic       bl;
        v = (d >> (4 * i)) & 16'h000F;
        case (v)
            4'd0: s = 7'b1111110;
            4'd1: s = 7'b0110000;
            4'd2: s = 7'b1101101;
            4'd3: s = 7'b1111001;
            4'd4: s = 7'b0110011;
            4'd5: s = 7'b1011011;
            4'd6: s = 7'b1011111;
            4'd7: s = 7'b1110000;
            4'd8: s = 7'b1111111;
            4'd9: s = 7'b1111011;
            default: s = 7'b0000001;
        endcase
        bl = 1'b0;
        if (blz && i == 2'd3 && d[15:12] == 4'd0) bl = 1'b1;
        if (blz && i == 2'd2 && d[15:12] == 4'd0 && d[11:8] == 4'd0) bl = 1'b1;
        if (blz && i == 2'd1 && d[15:12] == 4'd0 && d[11:8] == 4'd0 && d[7:4] == 4'd0) bl = 1'b1;
        if (bl) s = 7'b0000000;
        return {~s, ~dp[i]};
    endfunction

    task automatic model_reset();
        m_idx = 2'd0; m_sd = '0; m_dd = '0; m_sp = '0; m_dp = '0;
        m_sb = 1'b0; m_db = 1'b0; m_pend = 1'b0; m_wq = 1'b0;
        sb.delete();
    endtask

    // Drives one clock of stimulus and queues the output expected after that edge
    task automatic step(input logic tk, input logic ld, input logic [15:0] d,
                        input logic [3:0] dp, input logic blz);
        exp_t e;
        logic w;
        bus.scan_tick = tk; bus.load = ld;
        bus.din = d; bus.dp_in = dp; bus.blank_lz = blz;
        w = tk && (m_idx == 2'd3);
        e.fd = m_wq;
        m_wq = w;
        if (w && ld) begin
            m_dd = d; m_dp = dp; m_db = blz; m_pend = 1'b0;
        end else if (w && m_pend) begin
            m_dd = m_sd; m_dp = m_sp; m_db = m_sb; m_pend = 1'b0;
        end else if (ld) begin
            m_pend = 1'b1;
        end
        if (ld) begin
            m_sd = d; m_sp = dp; m_sb = blz;
        end
        if (tk) begin
            m_idx = m_idx + 2'd1;
            e.ctl = 4'b1111; e.segs = 8'hFF;
        end else begin
            e.ctl = ~(4'b0001 << m_idx);
            e.segs = ref_drive(m_idx, m_dd, m_dp, m_db);
        end
        sb.push_back(e);
        @(posedge clk); #1;
        bus.scan_tick = 1'b0; bus.load = 1'b0;
        if (bus.frame_done === 1'b1) fd_count++;
        for (int j = 0; j < 4; j++)
            if (bus.ftsd_ctl[j] === 1'b0) seen[j] = bus.segs;
    endtask

    task automatic test_reset();
        exp_t e;
        bus.scan_tick = 0; bus.load = 0; bus.din = '0; bus.dp_in = '0; bus.blank_lz = 0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ftsd_ctl !== 4'b1111 || bus.segs !== 8'hFF || bus.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got ctl=%b segs=%h fd=%b want 1111 ff 0",
                     bus.ftsd_ctl, bus.segs, bus.frame_done);
        end
        #5 rst_n = 1'b1;
        model_reset();
        step(0, 0, 16'h0, 4'h0, 0);
        e = sb.pop_front();
        checks++;
        if (bus.ftsd_ctl !== 4'b1110 || bus.segs !== 8'h03 || bus.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL first_drive got ctl=%b segs=%h fd=%b want 1110 03 0",
                     bus.ftsd_ctl, bus.segs, bus.frame_done);
        end
        checks++;
        if (bus.ftsd_ctl !== e.ctl || bus.segs !== e.segs) begin
            failures++;
            $display("FAIL first_drive_sb got %b %h want %b %h", bus.ftsd_ctl, bus.segs, e.ctl, e.segs);
        end
    endtask

    task automatic run_frames(input string name, input int pairs);
        exp_t e;
        for (int k = 0; k < 2 * pairs; k++) begin
            step((k % 2) == 0, 0, 16'h0, 4'h0, 0);
            e = sb.pop_front();
            checks++;
            if (bus.ftsd_ctl !== e.ctl || bus.segs !== e.segs || bus.frame_done !== e.fd) begin
                failures++;
                $display("FAIL %s step%0d got ctl=%b segs=%h fd=%b want ctl=%b segs=%h fd=%b",
                         name, k, bus.ftsd_ctl, bus.segs, bus.frame_done, e.ctl, e.segs, e.fd);
            end
            if (bus.segs === 8'h9F) saw_stale = 1'b1;
        end
    endtask

    task automatic test_digits();
        exp_t e;
        step(0, 1, 16'h1234, 4'b0100, 0);
        e = sb.pop_front();
        checks++;
        if (bus.ftsd_ctl !== e.ctl || bus.segs !== e.segs) begin
            failures++;
            $display("FAIL load_no_change got %b %h want %b %h", bus.ftsd_ctl, bus.segs, e.ctl, e.segs);
        end
        run_frames("digits", 8);
        checks++;
        if (seen[0] !== 8'h99 || seen[1] !== 8'h0D || seen[2] !== 8'h24 || seen[3] !== 8'h9F) begin
            failures++;
            $display("FAIL digits_1234 got %h %h %h %h want 99 0d 24 9f",
                     seen[0], seen[1], seen[2], seen[3]);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            step(k < 3, 0, 16'h0, 4'h0, 0);
            e = sb.pop_front();
            checks++;
            if (bus.ftsd_ctl !== e.ctl || bus.segs !== e.segs || bus.frame_done !== e.fd) begin
                failures++;
                $display("FAIL back_to_back step%0d got %b %h %b want %b %h %b",
                         k, bus.ftsd_ctl, bus.segs, bus.frame_done, e.ctl, e.segs, e.fd);
            end
        end
    endtask

    task automatic test_blank_lz();
        exp_t e;
        step(0, 1, 16'h0050, 4'b0000, 1);
        e = sb.pop_front();
        run_frames("blank_lz", 8);
        checks++;
        if (seen[3] !== 8'hFF || seen[2] !== 8'hFF || seen[1] !== 8'h49 || seen[0] !== 8'h03) begin
            failures++;
            $display("FAIL blank_lz_0050 got %h %h %h %h want 03 49 ff ff",
                     seen[0], seen[1], seen[2], seen[3]);
        end
    endtask

    task automatic test_multi_load();
        exp_t e;
        step(1, 0, 16'h0, 4'h0, 0);
        e = sb.pop_front();
        step(0, 1, 16'h1111, 4'h0, 0);
        e = sb.pop_front();
        step(0, 1, 16'h2222, 4'h0, 0);
        e = sb.pop_front();
        fd_count = 0;
        saw_stale = 1'b0;
        run_frames("multi_load", 8);
        checks++;
        if (seen[0] !== 8'h25 || seen[1] !== 8'h25 || seen[2] !== 8'h25 || seen[3] !== 8'h25
            || saw_stale) begin
            failures++;
            $display("FAIL multi_load got %h %h %h %h stale=%0d want 25 x4 stale=0",
                     seen[0], seen[1], seen[2], seen[3], saw_stale);
        end
        checks++;
        if (fd_count != 2) begin
            failures++;
            $display("FAIL frame_done_count got %0d want 2", fd_count);
        end
    endtask

    task automatic test_load_on_wrap();
        exp_t e;
        for (int k = 0; k < 4 && m_idx != 2'd3; k++) begin
            step(1, 0, 16'h0, 4'h0, 0);
            e = sb.pop_front();
        end
        step(1, 1, 16'h00AF, 4'h0, 0);
        e = sb.pop_front();
        checks++;
        if (dut.pending !== 1'b0) begin
            failures++;
            $display("FAIL wrap_load_pending got %b want 0", dut.pending);
        end
        run_frames("load_on_wrap", 8);
        checks++;
        if (seen[0] !== 8'hFD || seen[1] !== 8'hFD || seen[2] !== 8'h03 || seen[3] !== 8'h03) begin
            failures++;
            $display("FAIL wrap_load_00af got %h %h %h %h want fd fd 03 03",
                     seen[0], seen[1], seen[2], seen[3]);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        step(1, 0, 16'h0, 4'h0, 0);
        e = sb.pop_front();
        step(0, 1, 16'h9999, 4'hF, 0);
        e = sb.pop_front();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ftsd_ctl !== 4'b1111 || bus.segs !== 8'hFF || bus.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got ctl=%b segs=%h fd=%b want 1111 ff 0",
                     bus.ftsd_ctl, bus.segs, bus.frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_frames("after_reset", 8);
        checks++;
        if (seen[0] !== 8'h03 || seen[1] !== 8'h03 || seen[2] !== 8'h03 || seen[3] !== 8'h03) begin
            failures++;
            $display("FAIL stale_after_reset got %h %h %h %h want 03 x4",
                     seen[0], seen[1], seen[2], seen[3]);
        end
    endtask

    initial begin
        fd_count = 0;
        saw_stale = 1'b0;
        for (int j = 0; j < 4; j++) seen[j] = 8'h00;
        model_reset();
        test_reset();
        test_digits();
        test_back_to_back();
        test_blank_lz();
        test_multi_load();
        test_load_on_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ftsd_scan.md
FTSD_SCAN -- requirements
Module: ftsd_scan

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  system clock; the block is fully synchronous to clk, with no derived clocks.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 scan_tick  input  1  one-clk-cycle enable pulse from the frequency divider; advances the scan.
REQ-005 load  input  1  strobe; captures din, dp_in and blank_lz into the shadow register.
REQ-006 din  input  16  four BCD digits; din[3:0] is digit 0 (rightmost), din[15:12] is digit 3.
REQ-007 dp_in  input  4  decimal points, active-high, one bit per digit (bit i = digit i).
REQ-008 blank_lz  input  1  1 = enable leading-zero blanking.
REQ-009 ftsd_ctl  output  4  digit enables, active-low, registered; bit i drives digit i.
REQ-010 segs  output  8  segments, active-low, registered; segs[7:1] = a..g, segs[0] = dp.
REQ-011 frame_done  output  1  one-cycle pulse, registered, asserted on scan wrap.

Function
REQ-012 SHALL hold a 2-bit scan index idx; on each clk edge with scan_tick=1, idx <= idx+1, wrapping 3->0.
REQ-013 SHALL hold a shadow register {din, dp_in, blank_lz} written on load=1, plus a pending flag set by load.
REQ-014 SHALL hold a display register; it transfers from the shadow only on a wrap (scan_tick=1 while idx==3) with pending=1, and pending clears on that transfer.
REQ-015 On a wrap cycle with load=1, SHALL write the live din/dp_in/blank_lz to both shadow and display, leaving pending=0.
REQ-016 load while no wrap occurs SHALL NOT alter display or outputs; multiple loads within one frame SHALL keep only the last.
REQ-017 Anti-ghosting: on the edge where idx advances, ftsd_ctl <= 4'b1111 and segs <= 8'hFF for exactly one cycle.
REQ-018 On the following edge, ftsd_ctl SHALL drive only bit idx low, and segs SHALL drive the decoded display digit idx.
REQ-019 If scan_tick arrives during the blank cycle, SHALL advance again and restart the one-cycle blank.
REQ-020 Decode, as active-high segments a..g before inversion:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - codes 10..15 SHALL show '-' (g only).
REQ-021 The dp segment SHALL be the display dp bit of the digit being shown, inverted.
REQ-022 Leading-zero blanking (display blank_lz=1):
  - digit 3 SHALL be blanked if its value is 0.
  - digit 2 SHALL be blanked if digits 3 and 2 are both 0.
  - digit 1 SHALL be blanked if digits 3, 2 and 1 are all 0.
  - digit 0 SHALL never be blanked.
REQ-023 A blanked digit SHALL have segs[7:1]=7'h7F, dp still per REQ-021, and ftsd_ctl still active for that digit.
REQ-024 frame_done SHALL pulse high for one cycle on the edge following each wrap.
REQ-025 Latency SHALL be: scan_tick at edge N -> blank at N -> digit drive at N+1; frame_done at N+1 for wrap ticks.

Reset
REQ-026 rst_n=0 SHALL immediately set, independent of clk: idx=0, shadow=0, display=0, pending=0, ftsd_ctl=4'b1111, segs=8'hFF, frame_done=0.
REQ-027 After release, the first drive SHALL occur on the first clk edge: digit 0 is shown with value 0 (ftsd_ctl=4'b1110, segs=8'h03).
REQ-028 Reset mid-frame SHALL discard any pending load.

Verification
REQ-029 Reset, then 1 idle clk -> ftsd_ctl=4'b1110, segs=8'h03, frame_done=0.
REQ-030 load din=16'h1234, dp_in=4'b0100, then ticks through a wrap -> next frame shows digit0 '4'=8'h99, digit1 '3'=8'h0D, digit2 '2' with dp=8'h24, digit3 '1'=8'h9F; each digit is preceded by a 1-cycle all-off blank.
REQ-031 blank_lz=1, din=16'h0050 after transfer -> digit3 and digit2 show segs=8'hFF; digit1 shows '5'=8'h49; digit0 shows '0'=8'h03.
REQ-032 load 16'h1111 mid-frame, then load 16'h2222, then wrap -> display shows 2222 and never 1111; frame_done pulses exactly once per 4 ticks.
REQ-033 load asserted in the same cycle as the wrap tick with din=16'h00AF -> next frame shows digit0 and digit1 as '-' (8'h FD), with pending=0 afterwards.
REQ-034 rst_n asserted asynchronously mid-frame with load pending -> outputs reset immediately; after release no stale data appears.
